// File: rtl/jedro_1_pkg.sv
// jedro_1_pkg: shared opcodes, funct codes, enums and decode helpers for the jedro_1 core
package jedro_1_pkg;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_t t);
    case (t)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

  // alt selects SUB/SRA; the caller decides when the alternate encoding is meaningful
  function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/jedro_1_if.sv
// jedro_1_if: instruction and data RAM bus between the core and its memories
interface jedro_1_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_en_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  dmem_en_o;
  logic [3:0]            dmem_we_o;
  logic [ADDR_WIDTH-1:0] dmem_addr_o;
  logic [31:0]           dmem_wdata_o;
  logic [31:0]           dmem_rdata_i;
  modport master (
    output imem_en_o, imem_addr_o, dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  imem_rdata_i, dmem_rdata_i
  );
  modport slave (
    input  imem_en_o, imem_addr_o, dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output imem_rdata_i, dmem_rdata_i
  );
endinterface

// File: rtl/jedro_1_alu.sv
// jedro_1_alu: combinational RV32I integer ALU
module jedro_1_alu
  import jedro_1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] y_o
);
  logic [4:0] sh;
  assign sh = b_i[4:0];
  // select the operation result
  always_comb begin
    case (op_i)
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << sh;
      ALU_SLT:  y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {31'd0, a_i < b_i};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> sh;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> sh);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = a_i + b_i;
    endcase
  end
endmodule

// File: rtl/jedro_1_regfile.sv
// jedro_1_regfile: x1..x31 storage, two async read ports, one sync write port, x0 hardwired to zero
module jedro_1_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] regfile [0:30];
  assign rd1_o = ra1_i == 5'd0 ? 32'd0 : regfile[ra1_i - 5'd1];
  assign rd2_o = ra2_i == 5'd0 ? 32'd0 : regfile[ra2_i - 5'd1];
  // clear everything on reset, otherwise write rd unless it is x0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 31; i++) regfile[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regfile[wa_i - 5'd1] <= wd_i;
    end
  end
endmodule

// File: rtl/jedro_1_core.sv
// jedro_1_core: multi-cycle RV32I core with FETCH/EXEC/MEM sequencing
module jedro_1_core
  import jedro_1_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  jedro_1_if.master bus
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_4;
  logic [31:0]           ir_q, ir;
  logic [6:0]            opc;
  logic [4:0]            rd, rs1, rs2;
  logic [2:0]            f3;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [DATA_WIDTH-1:0] rs1_v, rs2_v, alu_b, alu_y, rf_wd, ld_sh;
  logic                  rf_we, take;
  alu_op_t               alu_op;
  logic [1:0]            off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_h;
  logic                  imem_en, dmem_en;
  logic [3:0]            dmem_we;
  logic [31:0]           dmem_addr, dmem_wdata;

  // in MEM the instruction RAM output is no longer ours, so use the latched word
  assign ir    = state_q == S_MEM ? ir_q : bus.imem_rdata_i;
  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign imm_i = imm_gen(ir, IMM_I);
  assign imm_s = imm_gen(ir, IMM_S);
  assign imm_b = imm_gen(ir, IMM_B);
  assign imm_u = imm_gen(ir, IMM_U);
  assign imm_j = imm_gen(ir, IMM_J);
  assign pc_4  = pc_q + 4;

  jedro_1_regfile u_rf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .wa_i  (rd),
    .we_i  (rf_we),
    .wd_i  (rf_wd),
    .rd1_o (rs1_v),
    .rd2_o (rs2_v)
  );

  // ADDI with a negative immediate sets ir[30], so only OP may select SUB
  assign alu_b  = (state_q == S_MEM || opc == OPC_LOAD || opc == OPC_JALR || opc == OPC_OP_IMM) ? imm_i :
                  opc == OPC_STORE ? imm_s : rs2_v;
  assign alu_op = opc == OPC_OP_IMM ? alu_dec(f3, ir[30] && f3 == F3_SR) :
                  opc == OPC_OP     ? alu_dec(f3, ir[30]) : ALU_ADD;

  jedro_1_alu u_alu (
    .a_i  (rs1_v),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y)
  );

  assign take    = (f3[2:1] == 2'b00 ? rs1_v == rs2_v :
                    f3[2:1] == 2'b10 ? $signed(rs1_v) < $signed(rs2_v) : rs1_v < rs2_v) ^ f3[0];
  assign off     = alu_y[1:0];
  assign ld_sh   = bus.dmem_rdata_i >> {off, 3'b000};
  assign ld_byte = ld_sh[7:0];
  assign ld_h    = off[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];

  // state, PC and latched instruction; reset discards any in-flight instruction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= BOOT_ADDR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_EXEC) ir_q <= bus.imem_rdata_i;
    end
  end

  // next state, PC, writeback and memory requests
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rf_we      = 1'b0;
    rf_wd      = alu_y;
    imem_en    = 1'b0;
    dmem_en    = 1'b0;
    dmem_we    = 4'b0000;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        imem_en = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_4;
        case (opc)
          OPC_OP_IMM, OPC_OP: rf_we = 1'b1;
          OPC_LUI: begin
            rf_we = 1'b1;
            rf_wd = imm_u;
          end
          OPC_AUIPC: begin
            rf_we = 1'b1;
            rf_wd = pc_q + imm_u;
          end
          OPC_JAL: begin
            rf_we = 1'b1;
            rf_wd = pc_4;
            pc_d  = pc_q + imm_j;
          end
          OPC_JALR: begin
            rf_we = 1'b1;
            rf_wd = pc_4;
            pc_d  = {alu_y[31:1], 1'b0};
          end
          OPC_BRANCH: pc_d = take ? pc_q + imm_b : pc_4;
          OPC_STORE: begin
            dmem_en    = 1'b1;
            dmem_addr  = {alu_y[31:2], 2'b00};
            dmem_we    = f3[1] ? 4'b1111 : f3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
            dmem_wdata = f3[1] ? rs2_v : f3[0] ? {2{rs2_v[15:0]}} : {4{rs2_v[7:0]}};
          end
          OPC_LOAD: begin
            dmem_en   = 1'b1;
            dmem_addr = {alu_y[31:2], 2'b00};
            pc_d      = pc_q;
            state_d   = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        rf_we   = 1'b1;
        rf_wd   = f3[1] ? bus.dmem_rdata_i :
                  f3[0] ? {{16{~f3[2] & ld_h[15]}}, ld_h} : {{24{~f3[2] & ld_byte[7]}}, ld_byte};
        pc_d    = pc_4;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.imem_en_o    = imem_en & ~rst_i;
  assign bus.imem_addr_o  = rst_i ? '0 : pc_q;
  assign bus.dmem_en_o    = dmem_en & ~rst_i;
  assign bus.dmem_we_o    = rst_i ? 4'b0000 : dmem_we;
  assign bus.dmem_addr_o  = rst_i ? '0 : dmem_addr;
  assign bus.dmem_wdata_o = rst_i ? '0 : dmem_wdata;
endmodule

// File: tb/tb_jedro_1_core.sv
// tb_jedro_1_core: directed instruction sequence with hand-computed register, PC and bus expectations
module tb_jedro_1_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  jedro_1_if bus ();

  jedro_1_core dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] instr);
    chk("fetch_en", {31'd0, bus.imem_en_o}, 32'd1);
    bus.imem_rdata_i = instr;
    tick();
    tick();
  endtask

  task automatic run_load(input logic [31:0] instr, input logic [31:0] word);
    chk("ld_fetch_en", {31'd0, bus.imem_en_o}, 32'd1);
    bus.imem_rdata_i = instr;
    tick();
    bus.dmem_rdata_i = word;
    tick();
    tick();
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.u_rf.regfile[i];
  endfunction

  initial begin
    logic [31:0] acc;
    bus.imem_rdata_i = 32'h0000_0013;
    bus.dmem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    acc = '0;
    for (int i = 0; i < 31; i++) acc |= rf(i);
    chk("rst_imem_addr", bus.imem_addr_o, 32'h0);
    chk("rst_imem_en", {31'd0, bus.imem_en_o}, 32'd0);
    chk("rst_dmem_en", {31'd0, bus.dmem_en_o}, 32'd0);
    chk("rst_dmem_we", {28'd0, bus.dmem_we_o}, 32'd0);
    chk("rst_regfile", acc, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_fetch_en", {31'd0, bus.imem_en_o}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("addi_pc", bus.imem_addr_o, 32'(4 * (k - 1)));
      run(32'h0000_8093 | (32'(k) << 20));
      chk("addi_x1", rf(0), 32'(k * (k + 1) / 2));
    end
    chk("pc16", bus.imem_addr_o, 32'd16);
    run(32'h0050_0013);
    chk("x0_nowrite_x1", rf(0), 32'd10);
    run(32'hFF80_0113);
    chk("addi_neg_x2", rf(1), 32'hFFFF_FFF8);
    run(32'h4011_5193);
    chk("srai_x3", rf(2), 32'hFFFF_FFFC);
    run(32'h01C1_5213);
    chk("srli_x4", rf(3), 32'h0000_000F);
    run(32'h0011_3293);
    chk("sltiu_x5", rf(4), 32'h0);
    chk("pc36", bus.imem_addr_o, 32'd36);
    run(32'h0800_0113);
    run(32'h0A50_0313);
    chk("x6", rf(5), 32'h0000_00A5);
    chk("sb_fetch_en", {31'd0, bus.imem_en_o}, 32'd1);
    bus.imem_rdata_i = 32'h0061_00A3;
    tick();
    chk("sb_en", {31'd0, bus.dmem_en_o}, 32'd1);
    chk("sb_addr", bus.dmem_addr_o, 32'h80);
    chk("sb_we", {28'd0, bus.dmem_we_o}, 32'b0010);
    chk("sb_wdata", bus.dmem_wdata_o, 32'hA5A5_A5A5);
    tick();
    chk("sb_next_pc", bus.imem_addr_o, 32'd48);
    bus.imem_rdata_i = 32'h0011_0383;
    tick();
    chk("lb_en", {31'd0, bus.dmem_en_o}, 32'd1);
    chk("lb_we", {28'd0, bus.dmem_we_o}, 32'd0);
    chk("lb_addr", bus.dmem_addr_o, 32'h80);
    bus.dmem_rdata_i = 32'h0000_A500;
    tick();
    chk("lb_mem_no_fetch", {31'd0, bus.imem_en_o}, 32'd0);
    tick();
    chk("lb_3cyc_fetch", {31'd0, bus.imem_en_o}, 32'd1);
    chk("lb_next_pc", bus.imem_addr_o, 32'd52);
    chk("lb_x7", rf(6), 32'hFFFF_FFA5);
    run_load(32'h0011_4383, 32'h0000_A500);
    chk("lbu_x7", rf(6), 32'h0000_00A5);
    chk("pc56", bus.imem_addr_o, 32'd56);
    bus.imem_rdata_i = 32'h0011_0383;
    tick();
    bus.dmem_rdata_i = 32'h0000_A500;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_no_wb", rf(6), 32'h0);
    chk("midrst_addr", bus.imem_addr_o, 32'h0);
    chk("midrst_en", {31'd0, bus.imem_en_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_fetch", {31'd0, bus.imem_en_o}, 32'd1);
    run(32'h0030_0093);
    run(32'h0030_0113);
    run(32'h0000_000F);
    run(32'h0000_0073);
    chk("nop_x1", rf(0), 32'd3);
    chk("nop_x2", rf(1), 32'd3);
    chk("nop_pc", bus.imem_addr_o, 32'd16);
    run(32'h0020_9463);
    chk("bne_nt_pc", bus.imem_addr_o, 32'd20);
    run(32'hFFDF_F06F);
    chk("jal_x0_pc", bus.imem_addr_o, 32'd16);
    run(32'h0020_8463);
    chk("beq_t_pc", bus.imem_addr_o, 32'd24);
    run(32'hFF1F_F0EF);
    chk("jal_pc", bus.imem_addr_o, 32'd8);
    chk("jal_x1", rf(0), 32'd28);
    run(32'h0010_8067);
    chk("jalr_pc", bus.imem_addr_o, 32'd28);
    run(32'h0000_80E7);
    chk("jalr_same_pc", bus.imem_addr_o, 32'd28);
    chk("jalr_same_x1", rf(0), 32'd32);
    run(32'h4020_81B3);
    chk("sub_x3", rf(2), 32'd29);
    run(32'h1234_5237);
    chk("lui_x4", rf(3), 32'h1234_5000);
    run(32'h0000_1297);
    chk("auipc_x5", rf(4), 32'h0000_1024);
    chk("final_pc", bus.imem_addr_o, 32'd40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
